pix_row_scheduler: RTL

//  Clocked scheduler for the per-PE pixel-row stores of the conv array. Holds one 5-pixel row per PE.

---
 rtl/pix_row_scheduler.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/pix_row_scheduler.sv
// pix_row_scheduler: per-PE 5-pixel row stores feeding one shared pixel stream.
// Each PE slot is used PE_index+1 times for its first row and KSIZE times for later rows.
// Pending PEs are arbitrated round-robin. Each granted use streams the 9-beat 3x3 window
// sequence p4,p3,p2, p3,p2,p1, p2,p1,p0.
// Optional feature macro: PIX_SCHED_STALL_CNT_EN adds a saturating stall_cnt output.
module pix_row_scheduler #(
  parameter int DWIDTH = 8,
  parameter int NUM_PE = 3,
  parameter int KSIZE  = 3,
  localparam int PEW   = ($clog2(NUM_PE) > 0) ? $clog2(NUM_PE) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  row_valid,
  output logic                  row_ready,
  input  logic [5*DWIDTH-1:0]   row_data,
  input  logic [PEW-1:0]        row_pe,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [DWIDTH-1:0]     pix_data,
  output logic [PEW-1:0]        pix_pe,
  output logic                  use_done,
`ifdef PIX_SCHED_STALL_CNT_EN
  output logic [31:0]           stall_cnt,
`endif
  output logic                  err_pe
);

  // Use counters must hold both the largest first-row count and KSIZE.
  localparam int MAXU = (NUM_PE > KSIZE) ? NUM_PE : KSIZE;
  localparam int UW   = $clog2(MAXU + 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state_reg, state_next;
  logic [5*DWIDTH-1:0]   slot_reg [NUM_PE];
  logic [UW-1:0]         uses_left_reg [NUM_PE];
  logic [NUM_PE-1:0]     first_reg;
  logic [NUM_PE-1:0]     pending;
  logic [PEW-1:0]        rr_reg, rr_next;
  logic [PEW-1:0]        grant_reg, grant_next;
  logic [3:0]            beat_reg, beat_next;
  logic                  use_done_reg;
  logic                  err_pe_reg;
  logic                  row_accept;
  logic                  row_in_range;
  logic                  last_accept;
  logic                  any_pending;
  logic [PEW-1:0]        search_pe;
  logic [2:0]            pix_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_pending
      assign pending[gi] = (uses_left_reg[gi] != '0);
    end
  endgenerate

  assign row_in_range = (int'(row_pe) < NUM_PE);
  assign row_accept   = row_valid && row_ready;
  assign pix_valid    = (state_reg == STREAM);
  assign pix_pe       = grant_reg;
  assign use_done     = use_done_reg;
  assign err_pe       = err_pe_reg;

  // Ready when the target slot is idle; out-of-range targets are always taken (and flagged).
  always_comb begin
    row_ready = 1'b1;
    for (int k = 0; k < NUM_PE; k++) begin
      if ((int'(row_pe) == k) && pending[k]) row_ready = 1'b0;
    end
  end

  // Round-robin search: first pending PE at or above rr_reg, wrapping.
  always_comb begin
    int idx;
    idx         = 0;
    any_pending = 1'b0;
    search_pe   = '0;
    for (int i = NUM_PE - 1; i >= 0; i--) begin
      idx = int'(rr_reg) + i;
      if (idx >= NUM_PE) idx = idx - NUM_PE;
      if (pending[idx]) begin
        any_pending = 1'b1;
        search_pe   = PEW'(idx);
      end
    end
  end

  // Next-state logic: grant in IDLE, walk 9 beats in STREAM, release after beat 8.
  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    beat_next   = beat_reg;
    rr_next     = rr_reg;
    last_accept = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_pending) begin
          state_next = STREAM;
          grant_next = search_pe;
          beat_next  = 4'd0;
        end
      end
      STREAM: begin
        if (pix_ready) begin
          if (beat_reg == 4'd8) begin
            last_accept = 1'b1;
            state_next  = IDLE;
            beat_next   = 4'd0;
            rr_next     = (int'(grant_reg) == NUM_PE - 1) ? '0 : grant_reg + PEW'(1);
          end else begin
            beat_next = beat_reg + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM, grant, beat counter and round-robin pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      beat_reg  <= 4'd0;
      rr_reg    <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      beat_reg  <= beat_next;
      rr_reg    <= rr_next;
    end
  end

  // Slot storage and use accounting; a load and a decrement never hit the same slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_reg <= '1;
      for (int k = 0; k < NUM_PE; k++) begin
        slot_reg[k]      <= '0;
        uses_left_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_PE; k++) begin
        if (row_accept && (int'(row_pe) == k)) begin
          slot_reg[k]      <= row_data;
          uses_left_reg[k] <= first_reg[k] ? UW'(k + 1) : UW'(KSIZE);
          first_reg[k]     <= 1'b0;
        end else if (last_accept && (int'(grant_reg) == k)) begin
          uses_left_reg[k] <= uses_left_reg[k] - UW'(1);
        end
      end
    end
  end

  // use_done pulse after the final beat, sticky out-of-range error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      use_done_reg <= 1'b0;
      err_pe_reg   <= 1'b0;
    end else begin
      use_done_reg <= last_accept;
      if (row_accept && !row_in_range) err_pe_reg <= 1'b1;
    end
  end

  // Window order: beat s selects pixel 4 - s/3 - s%3.
  always_comb begin
    case (beat_reg)
      4'd0:    pix_idx = 3'd4;
      4'd1:    pix_idx = 3'd3;
      4'd2:    pix_idx = 3'd2;
      4'd3:    pix_idx = 3'd3;
      4'd4:    pix_idx = 3'd2;
      4'd5:    pix_idx = 3'd1;
      4'd6:    pix_idx = 3'd2;
      4'd7:    pix_idx = 3'd1;
      default: pix_idx = 3'd0;
    endcase
  end

  // Output data is zero outside a stream so the reset/idle value is well defined.
  always_comb begin
    pix_data = '0;
    if (pix_valid) pix_data = slot_reg[grant_reg][int'(pix_idx)*DWIDTH +: DWIDTH];
  end

`ifdef PIX_SCHED_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;
  assign stall_cnt = stall_cnt_reg;

  // Saturating count of cycles a presented beat was refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= 32'd0;
    end else if (pix_valid && !pix_ready && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end
`endif

endmodule
